// File: rtl/spi_flash_xip.sv
// rtl/spi_flash_xip.sv - read-only SPI NOR execute-in-place bridge (word reads, writes acknowledged and dropped)
// Define SPI_FLASH_XIP_CONT_READ_EN to keep csb low between sequential reads and stream the next word.
module spi_flash_xip #(
    parameter int unsigned CLK_HALF = 1,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [23:0] addr,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        sck_q, sck_d;
    logic        csb_q, csb_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        half_end;
    logic        unused_addr_lsbs;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
    logic        cont_q, cont_d;
    logic [21:0] last_q, last_d;
    logic [8:0]  gap_q, gap_d;
`endif

    assign half_end         = (div_q == 8'(CLK_HALF - 1));
    assign unused_addr_lsbs = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            sck_q   <= 1'b0;
            csb_q   <= 1'b1;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
            cont_q  <= 1'b0;
            last_q  <= '0;
            gap_q   <= 9'(2 * CLK_HALF - 1);
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            csb_q   <= csb_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
            cont_q  <= cont_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        csb_d   = csb_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
        cont_d  = cont_q;
        last_d  = last_q;
        gap_d   = (gap_q != '0) ? gap_q - 9'd1 : gap_q;
`endif
        case (state_q)
            IDLE: begin
                div_d = '0;
                sck_d = 1'b0;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
                // gap_q enforces the minimum csb-high time before a new command sequence
                if (valid && gap_q == '0) begin
                    if (wstrb != 4'b0000) begin
                        rdata_d = '0;
                        state_d = DONE;
                        if (cont_q) begin
                            csb_d  = 1'b1;
                            cont_d = 1'b0;
                            gap_d  = 9'(2 * CLK_HALF - 1);
                        end
                    end else if (cont_q && addr[23:2] == last_q + 22'd1) begin
                        state_d = DATA;
                        bit_d   = 5'd31;
                        last_d  = addr[23:2];
                    end else if (cont_q) begin
                        csb_d  = 1'b1;
                        cont_d = 1'b0;
                        gap_d  = 9'(2 * CLK_HALF - 1);
                    end else begin
                        state_d = CMD;
                        csb_d   = 1'b0;
                        bit_d   = 5'd7;
                        tx_d    = {READ_CMD, addr[23:2], 2'b00};
                        last_d  = addr[23:2];
                    end
                end
`else
                if (valid) begin
                    if (wstrb != 4'b0000) begin
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = CMD;
                        csb_d   = 1'b0;
                        bit_d   = 5'd7;
                        tx_d    = {READ_CMD, addr[23:2], 2'b00};
                    end
                end
`endif
            end
            CMD, ADDR, DATA: begin
                if (!half_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        if (state_q == DATA) rx_d = {rx_q[30:0], flash_miso};
                    end else begin
                        // falling SCK: bit finished, present the next MOSI bit
                        tx_d  = {tx_q[30:0], 1'b0};
                        bit_d = bit_q - 5'd1;
                        if (bit_q == '0) begin
                            if (state_q == CMD) begin
                                state_d = ADDR;
                                bit_d   = 5'd23;
                            end else if (state_q == ADDR) begin
                                state_d = DATA;
                                bit_d   = 5'd31;
                            end else begin
                                state_d = DONE;
                                rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
`ifdef SPI_FLASH_XIP_CONT_READ_EN
                                cont_d  = 1'b1;
`else
                                csb_d   = 1'b1;
`endif
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flash_csb  = csb_q;
    assign flash_clk  = sck_q;
    assign flash_mosi = (state_q == CMD || state_q == ADDR) ? tx_q[31] : 1'b0;
    assign ready      = (state_q == DONE);
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_spi_flash_xip.sv
// tb/tb_spi_flash_xip.sv - bench for spi_flash_xip with a behavioural SPI flash per instance (CLK_HALF 1 and 3)
module tb_spi_flash_xip;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid [2];
    logic [23:0] addr  [2];
    logic [3:0]  wstrb [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        csb   [2];
    logic        sck   [2];
    logic        mosi  [2];
    logic        miso  [2];

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'h000104: return 8'h55;
            24'h000105: return 8'h66;
            24'h000106: return 8'h77;
            24'h000107: return 8'h88;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        logic [23:0] w;
        w = {a[23:2], 2'b00};
        return {byte_at(w + 24'd3), byte_at(w + 24'd2), byte_at(w + 24'd1), byte_at(w)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dev
        spi_flash_xip #(.CLK_HALF(g == 0 ? 1 : 3), .READ_CMD(8'h03)) u_dut (
            .clk(clk), .reset(reset), .valid(valid[g]), .addr(addr[g]), .wstrb(wstrb[g]),
            .rdata(rdata[g]), .ready(ready[g]), .flash_csb(csb[g]), .flash_clk(sck[g]),
            .flash_mosi(mosi[g]), .flash_miso(miso[g])
        );

        int          bc = 0;
        int          dbc = 0;
        int          cmd_cnt = 0;
        int          csb_falls = 0;
        int          csb_rises = 0;
        logic [31:0] sh = '0;
        logic [23:0] fa = '0;
        logic [7:0]  cap_cmd = '0;
        logic [23:0] cap_addr = '0;
        logic [7:0]  cur;
        logic        sck_prev = 1'b0;
        logic        miso_r = 1'b0;

        always @(sck[g] or csb[g]) begin
            if (csb[g]) begin
                bc  = 0;
                dbc = 0;
            end else if (sck[g] && !sck_prev) begin
                if (bc < 32) begin
                    sh = {sh[30:0], mosi[g]};
                    bc++;
                    if (bc == 32) begin
                        cap_cmd  = sh[31:24];
                        cap_addr = sh[23:0];
                        fa       = sh[23:0];
                        cmd_cnt++;
                    end
                end
            end else if (!sck[g] && sck_prev && bc == 32) begin
                cur    = byte_at(fa + 24'(dbc / 8));
                miso_r = cur[3'(7 - dbc % 8)];
                dbc++;
            end
            sck_prev = sck[g];
        end

        always @(negedge csb[g]) csb_falls++;
        always @(posedge csb[g]) csb_rises++;
        assign miso[g] = miso_r;
    end

    task automatic do_read(input int g, input logic [23:0] a, input logic [3:0] ws, input int drop_at,
                           output int lat, output int period, output logic [31:0] got,
                           output logic rdy_after, output logic [31:0] data_after);
        int   n = 1;
        int   r1 = -1;
        int   r2 = -1;
        logic prev;
        @(negedge clk);
        valid[g] = 1'b1;
        addr[g]  = a;
        wstrb[g] = ws;
        prev     = sck[g];
        lat      = -1;
        period   = -1;
        got      = '0;
        while (lat < 0 && n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sck[g] && !prev) begin
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
            end
            prev = sck[g];
            if (drop_at > 0 && n == drop_at) valid[g] = 1'b0;
            if (ready[g]) begin
                lat      = n;
                got      = rdata[g];
                valid[g] = 1'b0;
                wstrb[g] = '0;
            end
        end
        valid[g] = 1'b0;
        if (r2 > 0) period = r2 - r1;
        @(negedge clk);
        rdy_after  = ready[g];
        data_after = rdata[g];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            total++; if (csb[g] !== 1'b1) $display("FAIL reset_csb[%0d] got %b want 1", g, csb[g]); else passed++;
            total++; if (sck[g] !== 1'b0) $display("FAIL reset_sck[%0d] got %b want 0", g, sck[g]); else passed++;
            total++; if (mosi[g] !== 1'b0) $display("FAIL reset_mosi[%0d] got %b want 0", g, mosi[g]); else passed++;
            total++; if (ready[g] !== 1'b0) $display("FAIL reset_ready[%0d] got %b want 0", g, ready[g]); else passed++;
            total++; if (rdata[g] !== 32'h0) $display("FAIL reset_rdata[%0d] got %h want 0", g, rdata[g]); else passed++;
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read();
        int lat, per, c0;
        logic [31:0] got, da, exp;
        logic ra;
        c0 = g_dev[0].cmd_cnt;
        exp_q.push_back(32'h44332211);
        do_read(0, 24'h000100, 4'h0, 0, lat, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL read_data got %h want %h", got, exp); else passed++;
        total++; if (lat !== 130) $display("FAIL read_latency got %0d want 130", lat); else passed++;
        total++; if (g_dev[0].cap_cmd !== 8'h03) $display("FAIL read_opcode got %h want 03", g_dev[0].cap_cmd); else passed++;
        total++; if (g_dev[0].cap_addr !== 24'h000100) $display("FAIL read_addr got %h want 000100", g_dev[0].cap_addr); else passed++;
        total++; if (g_dev[0].cmd_cnt !== c0 + 1) $display("FAIL read_cmd_count got %0d want %0d", g_dev[0].cmd_cnt, c0 + 1); else passed++;
        total++; if (per !== 2) $display("FAIL read_sck_period got %0d want 2", per); else passed++;
        total++; if (ra !== 1'b0) $display("FAIL read_ready_width got %b want 0", ra); else passed++;
        total++; if (da !== exp) $display("FAIL read_rdata_hold got %h want %h", da, exp); else passed++;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
        total++; if (csb[0] !== 1'b0) $display("FAIL read_csb_idle got %b want 0", csb[0]); else passed++;
`else
        total++; if (csb[0] !== 1'b1) $display("FAIL read_csb_idle got %b want 1", csb[0]); else passed++;
`endif
    endtask

    task automatic test_align();
        int lat, per;
        logic [31:0] got, da, exp;
        logic ra;
        exp_q.push_back(32'h44332211);
        do_read(0, 24'h000103, 4'h0, 0, lat, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL align_data got %h want %h", got, exp); else passed++;
        total++; if (g_dev[0].cap_addr !== 24'h000100) $display("FAIL align_addr got %h want 000100", g_dev[0].cap_addr); else passed++;
    endtask

    task automatic test_write();
        int lat, per, f0;
        logic [31:0] got, da, exp;
        logic ra;
        f0 = g_dev[0].csb_falls;
        exp_q.push_back(32'h0);
        do_read(0, 24'h000200, 4'hF, 0, lat, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL write_rdata got %h want %h", got, exp); else passed++;
        total++; if (lat !== 2) $display("FAIL write_latency got %0d want 2", lat); else passed++;
        total++; if (g_dev[0].csb_falls !== f0) $display("FAIL write_csb_fell got %0d falls want %0d", g_dev[0].csb_falls, f0); else passed++;
        total++; if (da !== 32'h0) $display("FAIL write_rdata_hold got %h want 0", da); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, per, pulses;
        logic [31:0] got, da, exp;
        logic ra;
        @(negedge clk);
        valid[0] = 1'b1;
        addr[0]  = 24'h000100;
        wstrb[0] = 4'h0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (csb[0] !== 1'b1) $display("FAIL rstmid_csb got %b want 1", csb[0]); else passed++;
        total++; if (sck[0] !== 1'b0) $display("FAIL rstmid_sck got %b want 0", sck[0]); else passed++;
        total++; if (ready[0] !== 1'b0) $display("FAIL rstmid_ready got %b want 0", ready[0]); else passed++;
        valid[0] = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (ready[0]) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL rstmid_no_ready got %0d pulses want 0", pulses); else passed++;
        exp_q.push_back(32'h44332211);
        do_read(0, 24'h000100, 4'h0, 0, lat, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL rstmid_reread got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, per, c0, r0;
        logic [31:0] got, da, exp;
        logic ra;
        r0 = g_dev[0].csb_rises;
        exp_q.push_back(word_at(24'h000100));
        do_read(0, 24'h000100, 4'h0, 0, lat1, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL seq_first got %h want %h", got, exp); else passed++;
        c0 = g_dev[0].cmd_cnt;
`ifndef SPI_FLASH_XIP_CONT_READ_EN
        total++; if (g_dev[0].csb_rises !== r0 + 1) $display("FAIL seq_csb_pulse got %0d rises want %0d", g_dev[0].csb_rises, r0 + 1); else passed++;
`endif
        exp_q.push_back(word_at(24'h000104));
        do_read(0, 24'h000104, 4'h0, 0, lat2, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL seq_second got %h want %h", got, exp); else passed++;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
        total++; if (lat2 !== 66) $display("FAIL seq_latency got %0d want 66", lat2); else passed++;
        total++; if (g_dev[0].cmd_cnt !== c0) $display("FAIL seq_no_opcode got %0d cmds want %0d", g_dev[0].cmd_cnt, c0); else passed++;
`else
        total++; if (lat2 !== 130) $display("FAIL seq_latency got %0d want 130", lat2); else passed++;
        total++; if (g_dev[0].cmd_cnt !== c0 + 1) $display("FAIL seq_opcode got %0d cmds want %0d", g_dev[0].cmd_cnt, c0 + 1); else passed++;
`endif
    endtask

    task automatic test_valid_drop();
        int lat, per;
        logic [31:0] got, da, exp;
        logic ra;
        exp_q.push_back(word_at(24'h000108));
        do_read(0, 24'h000108, 4'h0, 5, lat, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL drop_data got %h want %h", got, exp); else passed++;
`ifdef SPI_FLASH_XIP_CONT_READ_EN
        total++; if (lat !== 66) $display("FAIL drop_latency got %0d want 66", lat); else passed++;
`else
        total++; if (lat !== 130) $display("FAIL drop_latency got %0d want 130", lat); else passed++;
`endif
    endtask

    task automatic test_divider();
        int lat, per;
        logic [31:0] got, da, exp;
        logic ra;
        exp_q.push_back(32'h44332211);
        do_read(1, 24'h000100, 4'h0, 0, lat, per, got, ra, da);
        exp = exp_q.pop_front();
        total++; if (got !== exp) $display("FAIL div_data got %h want %h", got, exp); else passed++;
        total++; if (lat !== 386) $display("FAIL div_latency got %0d want 386", lat); else passed++;
        total++; if (per !== 6) $display("FAIL div_sck_period got %0d want 6", per); else passed++;
        total++; if (g_dev[1].cap_cmd !== 8'h03) $display("FAIL div_opcode got %h want 03", g_dev[1].cap_cmd); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            valid[g] = 1'b0;
            addr[g]  = '0;
            wstrb[g] = '0;
        end
        test_reset();
        test_read();
        test_align();
        test_write();
        test_reset_mid();
        test_back_to_back();
        test_valid_drop();
        test_divider();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
